// File: rtl/rsa_modexp_engine.sv
// rsa_modexp_engine
//   RSA modular exponentiation: result = msg^key mod n, with key taken from an
//   internally held public (e) or private (d) exponent register. Right-to-left
//   binary exponentiation driven by one shared bit-serial interleaved modular
//   multiplier (W+1 cycles per multiply or square).
//
//   Optional build macro: RSA_CONST_TIME_EN
//     defined   - a MUL runs for every exponent bit; its product is discarded
//                 when the bit is 0, so latency does not depend on the exponent.
//     undefined - a MUL runs only for exponent bits that are 1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (aborts any operation)
//   key_we_i   write stored exponent (accepted in IDLE only)
//   key_sel_i  1 = write e, 0 = write d
//   key_in_i   exponent value to write
//   start_i    start an operation (accepted in IDLE only)
//   enc_dec_i  1 = use e, 0 = use d (sampled with start_i)
//   msg_in_i   message / ciphertext (sampled with start_i)
//   n_in_i     modulus (sampled with start_i)
//   busy_o     operation in progress (through the done cycle)
//   done_o     one-cycle completion pulse
//   err_o      operand error (n < 2 or msg >= n) for the completed operation
//   result_o   msg^key mod n, 0 on error; held until the next completion
module rsa_modexp_engine #(
  parameter int W     = 1024,
  parameter int EXP_W = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_we_i,
  input  logic             key_sel_i,
  input  logic [EXP_W-1:0] key_in_i,
  input  logic             start_i,
  input  logic             enc_dec_i,
  input  logic [W-1:0]     msg_in_i,
  input  logic [W-1:0]     n_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [W-1:0]     result_o
);

`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  localparam int CW = $clog2(W + 1);
  localparam int IW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MUL, S_SQR, S_DONE} state_t;

  state_t           state_q;
  logic [EXP_W-1:0] e_q, d_q, exp_q;
  logic [W-1:0]     n_q, acc_q, base_q, result_q;
  logic [W+1:0]     r_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    i_q;
  logic             busy_q, done_q, err_q;

  // Multiplier datapath: MUL computes acc*base, SQR computes base*base.
  // Operand a is scanned MSB first; cnt_q counts processed bits.
  logic [W-1:0]     mul_a, a_mask;
  logic             a_bit;
  logic [CW-1:0]    bit_idx;
  logic [W+1:0]     n_ext, b_ext, t0, t1, t2;
  logic [EXP_W-1:0] exp_nxt;

  always_comb begin
    mul_a   = (state_q == S_MUL) ? acc_q : base_q;
    bit_idx = CW'(W - 1) - cnt_q;
    a_mask  = {{(W-1){1'b0}}, 1'b1} << bit_idx;
    a_bit   = |(mul_a & a_mask);
    n_ext   = {2'b00, n_q};
    b_ext   = {2'b00, base_q};
    // r < n, so 2r + b < 3n: two conditional subtractions restore r < n.
    t0      = {r_q[W:0], 1'b0} + (a_bit ? b_ext : '0);
    t1      = (t0 >= n_ext) ? t0 - n_ext : t0;
    t2      = (t1 >= n_ext) ? t1 - n_ext : t1;
    exp_nxt = exp_q >> 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      e_q      <= '0;
      d_q      <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      base_q   <= '0;
      result_q <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      i_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_we_i) begin
            if (key_sel_i) e_q <= key_in_i;
            else           d_q <= key_in_i;
          end
          if (start_i) begin
            // Non-blocking read: a same-cycle key write is not seen here.
            exp_q   <= enc_dec_i ? e_q : d_q;
            base_q  <= msg_in_i;
            n_q     <= n_in_i;
            busy_q  <= 1'b1;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (n_q < W'(2) || base_q >= n_q) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q   <= W'(1);
            i_q     <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
            state_q <= (CONST_TIME || exp_q[0]) ? S_MUL : S_SQR;
          end
        end
        S_MUL, S_SQR: begin
          if (cnt_q != CW'(W)) begin
            r_q   <= t2;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            // Writeback cycle.
            cnt_q <= '0;
            r_q   <= '0;
            if (state_q == S_MUL) begin
              if (exp_q[0]) acc_q <= r_q[W-1:0];
              state_q <= S_SQR;
            end else begin
              base_q <= r_q[W-1:0];
              exp_q  <= exp_nxt;
              if (i_q == IW'(EXP_W - 1)) begin
                result_q <= acc_q;
                err_q    <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                i_q     <= i_q + IW'(1);
                state_q <= (CONST_TIME || exp_nxt[0]) ? S_MUL : S_SQR;
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Scoreboard bench for rsa_modexp_engine at W=8, EXP_W=8, n=143, e=7, d=103.
// Stimulus pushes the hand-computed result/err/latency; a negedge monitor pops
// and compares on every done pulse.
module tb_rsa_modexp_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_we = 1'b0, key_sel = 1'b0, start = 1'b0, enc_dec = 1'b0;
  logic [7:0] key_in = '0, msg_in = '0, n_in = '0;
  logic       busy, done, err;
  logic [7:0] result;

  rsa_modexp_engine #(.W(8), .EXP_W(8)) dut (
    .clk(clk), .rst(rst),
    .key_we_i(key_we), .key_sel_i(key_sel), .key_in_i(key_in),
    .start_i(start), .enc_dec_i(enc_dec), .msg_in_i(msg_in), .n_in_i(n_in),
    .busy_o(busy), .done_o(done), .err_o(err), .result_o(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic       er;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Latency in cycles for a non-error operation, given popcount of exponent.
  function automatic int lat_for(input int pc);
`ifdef RSA_CONST_TIME_EN
    return 2 + 16 * 9;
`else
    return 2 + (8 + pc) * 9;
`endif
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        $display("op done: result=%0d err=%0d lat=%0d", result, err, cyc - x.t0);
        chk("result", int'(result), int'(x.res));
        chk("err", int'(err), int'(x.er));
        chk("latency", cyc - x.t0, x.lat);
        chk("busy_in_done", int'(busy), 1);
      end
    end
  end

  task automatic write_key(input bit sel, input logic [7:0] val);
    @(negedge clk);
    key_we = 1'b1; key_sel = sel; key_in = val;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic do_op(input bit enc, input logic [7:0] msg, input logic [7:0] n,
                       input logic [7:0] res, input bit er, input int lat);
    exp_t x;
    @(negedge clk);
    x.res = res; x.er = er; x.lat = lat; x.t0 = cyc;
    sb.push_back(x);
    start = 1'b1; enc_dec = enc; msg_in = msg; n_in = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout actual=%0d required=0 pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_result", int'(result), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1/2: encrypt and decrypt round trip
    write_key(1'b1, 8'd7);
    write_key(1'b0, 8'd103);
    do_op(1'b1, 8'd9, 8'd143, 8'd48, 1'b0, lat_for(3));  wait_idle();
    chk("busy_after_done", int'(busy), 0);
    chk("result_held", int'(result), 48);
    do_op(1'b0, 8'd48, 8'd143, 8'd9, 1'b0, lat_for(5));  wait_idle();

    // 3: operand errors
    do_op(1'b1, 8'd143, 8'd143, 8'd0, 1'b1, 2);          wait_idle();
    do_op(1'b1, 8'd0, 8'd1, 8'd0, 1'b1, 2);              wait_idle();

    // 4: zero exponent and zero message
    write_key(1'b0, 8'd0);
    do_op(1'b0, 8'd100, 8'd143, 8'd1, 1'b0, lat_for(0)); wait_idle();
    do_op(1'b1, 8'd0, 8'd143, 8'd0, 1'b0, lat_for(3));   wait_idle();
    write_key(1'b0, 8'd103);

    // key write together with start: op uses old e=7, then e=3 (9^3 mod 143 = 14)
    begin
      exp_t x;
      @(negedge clk);
      x.res = 8'd48; x.er = 1'b0; x.lat = lat_for(3); x.t0 = cyc;
      sb.push_back(x);
      start = 1'b1; enc_dec = 1'b1; msg_in = 8'd9; n_in = 8'd143;
      key_we = 1'b1; key_sel = 1'b1; key_in = 8'd3;
      @(negedge clk);
      start = 1'b0; key_we = 1'b0;
    end
    wait_idle();
    do_op(1'b1, 8'd9, 8'd143, 8'd14, 1'b0, lat_for(2));  wait_idle();
    write_key(1'b1, 8'd7);

    // 5: start and key_we hammered while busy are dropped
    do_op(1'b1, 8'd9, 8'd143, 8'd48, 1'b0, lat_for(3));
    for (int k = 0; k < 30; k++) begin
      start = 1'b1; key_we = 1'b1; key_sel = k[0]; key_in = 8'd5;
      enc_dec = ~k[0]; msg_in = 8'd3; n_in = 8'd200;
      @(negedge clk);
    end
    start = 1'b0; key_we = 1'b0;
    wait_idle();
    do_op(1'b0, 8'd48, 8'd143, 8'd9, 1'b0, lat_for(5));  wait_idle();

    // 6: reset mid-MUL aborts and clears keys
    do_op(1'b1, 8'd9, 8'd143, 8'd48, 1'b0, lat_for(3));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    repeat (150) @(negedge clk);
    do_op(1'b1, 8'd9, 8'd143, 8'd1, 1'b0, lat_for(0));   wait_idle();
    write_key(1'b1, 8'd7);
    write_key(1'b0, 8'd103);
    do_op(1'b1, 8'd9, 8'd143, 8'd48, 1'b0, lat_for(3));  wait_idle();
    do_op(1'b0, 8'd48, 8'd143, 8'd9, 1'b0, lat_for(5));  wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
